// File: rtl/addsub_arbiter_if.sv
// Bundle of request, response and datapath signals shared by addsub_arbiter and its environment.
// The slave modport is the arbiter's view; master is the view of whoever drives requests and the datapath.
interface addsub_arbiter_if #(
  parameter int DATA_WIDTH = 4
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_op;
  logic [2*DATA_WIDTH-1:0] req_a;
  logic [2*DATA_WIDTH-1:0] req_b;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [DATA_WIDTH:0]     rsp_data;
  logic                    dp_en;
  logic                    dp_control;
  logic [DATA_WIDTH-1:0]   dp_data1;
  logic [DATA_WIDTH-1:0]   dp_data2;
  logic [DATA_WIDTH:0]     dp_y;
  logic                    busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, dp_y,
    output req_ready, rsp_valid, rsp_data, dp_en, dp_control, dp_data1, dp_data2, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, dp_y,
    input  req_ready, rsp_valid, rsp_data, dp_en, dp_control, dp_data1, dp_data2, busy
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one registered add/sub datapath: IDLE -> ISSUE -> CAPTURE -> RESP.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first); default is round-robin.
module addsub_arbiter #(
  parameter int DATA_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  addsub_arbiter_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t         state_q;
  state_t         state_d;
  logic           owner_q;
  logic           grant_idx;
  logic [1:0]     grant;
  logic           accept;
  logic           rsp_done;
  logic           dp_control_q;
  logic [W-1:0]   dp_data1_q;
  logic [W-1:0]   dp_data2_q;
  logic [W:0]     rsp_data_q;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
  logic           last_q;
`endif

  // Winner index is only meaningful when at least one request is valid.
  always_comb begin
    grant_idx = 1'b0;
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    grant_idx = ~bus.req_valid[0];
`else
    if (&bus.req_valid) begin
      grant_idx = ~last_q;
    end else begin
      grant_idx = ~bus.req_valid[0];
    end
`endif
  end

  always_comb begin
    grant = 2'b00;
    if (rst && (state_q == IDLE) && (|bus.req_valid)) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

  assign accept   = |(bus.req_valid & grant);
  assign rsp_done = (state_q == RESP) && bus.rsp_ready[owner_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands go straight into the datapath-facing registers so they hold after ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= 1'b0;
      dp_control_q <= 1'b0;
      dp_data1_q   <= '0;
      dp_data2_q   <= '0;
      rsp_data_q   <= '0;
    end else begin
      if (accept) begin
        owner_q      <= grant_idx;
        dp_control_q <= bus.req_op[grant_idx];
        dp_data1_q   <= grant_idx ? bus.req_a[W +: W] : bus.req_a[0 +: W];
        dp_data2_q   <= grant_idx ? bus.req_b[W +: W] : bus.req_b[0 +: W];
      end
      if (state_q == CAPTURE) begin
        rsp_data_q <= bus.dp_y;
      end
    end
  end

`ifndef ADDSUB_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (rsp_done) begin
      last_q <= owner_q;
    end
  end
`endif

  always_comb begin
    bus.req_ready  = grant;
    bus.rsp_valid  = 2'b00;
    bus.dp_en      = 1'b0;
    bus.busy       = (state_q != IDLE);
    bus.rsp_data   = rsp_data_q;
    bus.dp_control = dp_control_q;
    bus.dp_data1   = dp_data1_q;
    bus.dp_data2   = dp_data2_q;
    case (state_q)
      ISSUE:   bus.dp_en = 1'b1;
      RESP:    bus.rsp_valid = owner_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: vector table, reset corner cases and randomized traffic against a simple model.
// The datapath is emulated here as a one-cycle registered adder/subtractor.
module tb_addsub_arbiter;
  localparam int W = 4;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         stall;
    logic       win;
    logic [4:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] dp_y_q = '0;
  int total = 0;
  int bad = 0;
  logic model_last = 1'b1;
  vec_t vecs[$];

  addsub_arbiter_if #(.DATA_WIDTH(W)) bus ();

  addsub_arbiter #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.dp_en) begin
      dp_y_q <= bus.dp_control ? ({1'b0, bus.dp_data1} + {1'b0, bus.dp_data2})
                               : ({1'b0, bus.dp_data1} - {1'b0, bus.dp_data2});
    end
  end
  assign bus.dp_y = dp_y_q;

  function automatic logic model_winner(input logic [1:0] v, input logic last);
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    return v[0] ? 1'b0 : 1'b1;
`else
    if (v[0] && v[1]) return ~last;
    return v[0] ? 1'b0 : 1'b1;
`endif
  endfunction

  function automatic logic [4:0] model_result(input logic op, input int a, input int b);
    int r;
    r = op ? (a + b) : (a - b);
    return 5'(r & 31);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; requests stay asserted throughout to show they are ignored outside IDLE.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b, input int stall, input logic exp_win,
                               input logic [4:0] exp_data);
    logic [1:0] own_bit;
    own_bit = exp_win ? 2'b10 : 2'b01;
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = 2'b00;
    #1;
    checkOutput("grant", 32'(bus.req_ready), 32'(own_bit));
    cycle();
    checkOutput("issue_dp_en", 32'(bus.dp_en), 32'd1);
    checkOutput("issue_op", 32'(bus.dp_control), 32'(op[exp_win]));
    checkOutput("issue_a", 32'(bus.dp_data1), 32'(exp_win ? a[7:4] : a[3:0]));
    checkOutput("issue_b", 32'(bus.dp_data2), 32'(exp_win ? b[7:4] : b[3:0]));
    checkOutput("issue_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("issue_busy", 32'(bus.busy), 32'd1);
    cycle();
    checkOutput("capture_dp_en", 32'(bus.dp_en), 32'd0);
    checkOutput("capture_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    cycle();
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(own_bit));
    checkOutput("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    for (int i = 0; i < stall; i++) begin
      bus.rsp_ready = ~own_bit;
      cycle();
      checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 32'(own_bit));
      checkOutput("stall_rsp_data", 32'(bus.rsp_data), 32'(exp_data));
      checkOutput("stall_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("stall_dp_en", 32'(bus.dp_en), 32'd0);
    end
    bus.rsp_ready = own_bit;
    cycle();
    bus.rsp_ready = 2'b00;
    checkOutput("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("done_busy", 32'(bus.busy), 32'd0);
    checkOutput("done_rsp_hold", 32'(bus.rsp_data), 32'(exp_data));
    model_last = exp_win;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    checkOutput({tag, "_dp_en"}, 32'(bus.dp_en), 32'd0);
    checkOutput({tag, "_dp_control"}, 32'(bus.dp_control), 32'd0);
    checkOutput({tag, "_dp_data1"}, 32'(bus.dp_data1), 32'd0);
    checkOutput({tag, "_dp_data2"}, 32'(bus.dp_data2), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [1:0] v;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       w;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    vecs.push_back('{2'b11, 2'b01, 8'h39, 8'h58, 0, 1'b0, 5'h11});
    vecs.push_back('{2'b11, 2'b01, 8'h39, 8'h58, 0, 1'b0, 5'h11});
    vecs.push_back('{2'b11, 2'b10, 8'hF2, 8'hF7, 5, 1'b0, 5'h1B});
    vecs.push_back('{2'b11, 2'b10, 8'hF2, 8'hF7, 1, 1'b0, 5'h1B});
    vecs.push_back('{2'b10, 2'b10, 8'h40, 8'h00, 2, 1'b1, 5'h04});
    vecs.push_back('{2'b11, 2'b00, 8'h00, 8'h01, 0, 1'b0, 5'h1F});
    vecs.push_back('{2'b01, 2'b01, 8'h0F, 8'h0F, 0, 1'b0, 5'h1E});
    vecs.push_back('{2'b11, 2'b00, 8'h85, 8'h35, 0, 1'b0, 5'h00});
`else
    vecs.push_back('{2'b11, 2'b01, 8'h39, 8'h58, 0, 1'b0, 5'h11});
    vecs.push_back('{2'b11, 2'b01, 8'h39, 8'h58, 0, 1'b1, 5'h1E});
    vecs.push_back('{2'b11, 2'b10, 8'hF2, 8'hF7, 5, 1'b0, 5'h1B});
    vecs.push_back('{2'b11, 2'b10, 8'hF2, 8'hF7, 1, 1'b1, 5'h1E});
    vecs.push_back('{2'b10, 2'b10, 8'h40, 8'h00, 2, 1'b1, 5'h04});
    vecs.push_back('{2'b11, 2'b00, 8'h00, 8'h01, 0, 1'b0, 5'h1F});
    vecs.push_back('{2'b01, 2'b01, 8'h0F, 8'h0F, 0, 1'b0, 5'h1E});
    vecs.push_back('{2'b11, 2'b00, 8'h85, 8'h35, 0, 1'b1, 5'h05});
`endif

    // Requests held during reset must not be granted.
    bus.req_valid = 2'b11;
    bus.req_op    = 2'b11;
    bus.req_a     = 8'h12;
    bus.req_b     = 8'h34;
    bus.rsp_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_all_zero("reset");
    end
    bus.req_valid = 2'b00;
    rst = 1'b1;
    cycle();
    checkOutput("post_reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_reset_dp_en", 32'(bus.dp_en), 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall,
                    vecs[i].win, vecs[i].data);
    end

    // Reset pulse while the datapath result is being captured.
    bus.req_valid = 2'b01;
    bus.req_op    = 2'b01;
    bus.req_a     = 8'h06;
    bus.req_b     = 8'h01;
    cycle();
    cycle();
    bus.req_valid = 2'b00;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    cycle();
    rst = 1'b1;
    model_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkOutput("dropped_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("dropped_busy", 32'(bus.busy), 32'd0);
    end
    applyStimulus(2'b11, 2'b11, 8'h27, 8'h13, 0, 1'b0, 5'h0A);

    for (int n = 0; n < 40; n++) begin
      v  = 2'($urandom_range(1, 3));
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      w  = model_winner(v, model_last);
      applyStimulus(v, op, a, b, $urandom_range(0, 3), w,
                    model_result(op[w], w ? int'(a[7:4]) : int'(a[3:0]),
                                 w ? int'(b[7:4]) : int'(b[3:0])));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
